// File: rtl/acoustics_pkg.sv
// Shared definitions for the hydrophone acquisition path.
// Holds the capture FSM encoding and the default ADC frame layout.
package acoustics_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        SHIFT,
        DONE
    } cap_state_t;

endpackage

// File: rtl/adc_spi_capture_if.sv
// Bundle of ADC serial lines, shared chip-select and captured-sample outputs.
// The master modport is the capture block; the slave modport is the ADC/consumer side.
interface adc_spi_capture_if
    import acoustics_pkg::*;
#(
    parameter int unsigned DATA_BITS = acoustics_pkg::DATA_BITS
);
    logic                 enable;
    logic                 adc1;
    logic                 adc2;
    logic                 adc3;
    logic                 adc4;
    logic                 cs_n;
    logic [DATA_BITS-1:0] sample1;
    logic [DATA_BITS-1:0] sample2;
    logic [DATA_BITS-1:0] sample3;
    logic [DATA_BITS-1:0] sample4;
    logic [3:0]           lead_err;
    logic                 data_ready;

    modport master (
        input  enable, adc1, adc2, adc3, adc4,
        output cs_n, sample1, sample2, sample3, sample4, lead_err, data_ready
    );

    modport slave (
        output enable, adc1, adc2, adc3, adc4,
        input  cs_n, sample1, sample2, sample3, sample4, lead_err, data_ready
    );
endinterface

// File: rtl/adc_spi_capture_lane.sv
// One ADC data lane: frame shift register plus the sample / lead-error holding registers.
// The capture pulse coincides with the final shift, so outputs load from the post-shift value.
module adc_shift_lane
    import acoustics_pkg::*;
#(
    parameter int unsigned FRAME_BITS = acoustics_pkg::FRAME_BITS,
    parameter int unsigned DATA_BITS  = acoustics_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 shift_en,
    input  logic                 capture,
    input  logic                 din,
    output logic [DATA_BITS-1:0] sample,
    output logic                 lead_err
);
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_d;

    always_comb begin
        frame_d = {frame_q[FRAME_BITS-2:0], din};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            frame_q  <= '0;
            sample   <= '0;
            lead_err <= 1'b0;
        end else begin
            if (shift_en) begin
                frame_q <= frame_d;
            end
            if (capture) begin
                sample   <= frame_d[DATA_BITS-1:0];
                lead_err <= |frame_d[FRAME_BITS-1:DATA_BITS];
            end
        end
    end
endmodule

// File: rtl/adc_spi_capture.sv
// Four-channel ADC frame capture: drives shared cs_n, shifts all lanes in parallel,
// and strobes data_ready for one cycle with the new samples and lead-zero errors.
module adc_spi_capture
    import acoustics_pkg::*;
#(
    parameter int unsigned FRAME_BITS   = acoustics_pkg::FRAME_BITS,
    parameter int unsigned DATA_BITS    = acoustics_pkg::DATA_BITS,
    parameter int unsigned LEAD_ZEROS   = acoustics_pkg::LEAD_ZEROS,
    parameter int unsigned QUIET_CYCLES = 2
) (
    input logic               clk,
    input logic               reset_b,
    adc_spi_capture_if.master bus
);
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    if (FRAME_BITS != LEAD_ZEROS + DATA_BITS) begin : g_bad_frame
        $error("adc_spi_capture: FRAME_BITS must equal LEAD_ZEROS + DATA_BITS");
    end
    if (QUIET_CYCLES < 1) begin : g_bad_quiet
        $error("adc_spi_capture: QUIET_CYCLES must be at least 1");
    end

    cap_state_t    state_q;
    cap_state_t    next_state;
    logic [BW-1:0] bit_cnt;
    logic [QW-1:0] quiet_cnt;
    logic          cs_n_d;
    logic          ready_d;
    logic          shift_en;
    logic          capture;
    logic          cs_n_q;
    logic          ready_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q <= next_state;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            if (state_q == QUIET && next_state == QUIET) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end else begin
                quiet_cnt <= '0;
            end
            if (state_q == SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        unique case (state_q)
            IDLE:  if (bus.enable) next_state = QUIET;
            QUIET: begin
                if (!bus.enable) begin
                    next_state = IDLE;
                end else if (quiet_cnt == QUIET_LAST) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: if (bit_cnt == BIT_LAST) next_state = DONE;
            DONE:  next_state = bus.enable ? QUIET : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // cs_n and data_ready are decoded from next_state so the registered copies track the state.
    always_comb begin
        cs_n_d   = (next_state != SHIFT);
        ready_d  = (next_state == DONE);
        shift_en = (state_q == SHIFT);
        capture  = (state_q == SHIFT) && (bit_cnt == BIT_LAST);
    end

    logic [3:0]           adc_bits;
    logic [DATA_BITS-1:0] lane_sample [4];
    logic [3:0]           lane_err;

    assign adc_bits = {bus.adc4, bus.adc3, bus.adc2, bus.adc1};

    for (genvar g = 0; g < 4; g++) begin : g_lane
        adc_shift_lane #(
            .FRAME_BITS (FRAME_BITS),
            .DATA_BITS  (DATA_BITS)
        ) u_lane (
            .clk      (clk),
            .reset_b  (reset_b),
            .shift_en (shift_en),
            .capture  (capture),
            .din      (adc_bits[g]),
            .sample   (lane_sample[g]),
            .lead_err (lane_err[g])
        );
    end

    assign bus.cs_n       = cs_n_q;
    assign bus.data_ready = ready_q;
    assign bus.sample1    = lane_sample[0];
    assign bus.sample2    = lane_sample[1];
    assign bus.sample3    = lane_sample[2];
    assign bus.sample4    = lane_sample[3];
    assign bus.lead_err   = lane_err;
endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: ADC frame model feeding a scoreboard of expected
// samples, plus cs_n / data_ready timing measured by a negedge monitor.
module tb_adc_spi_capture;
    typedef struct packed {
        logic [3:0][11:0] s;
        logic [3:0]       le;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b;
    int unsigned total = 0;
    int unsigned bad = 0;

    logic [3:0][15:0] frame_q [$];
    exp_t             exp_q [$];

    always #5 clk = ~clk;

    adc_spi_capture_if #(.DATA_BITS(12)) bus ();

    adc_spi_capture #(
        .FRAME_BITS   (16),
        .DATA_BITS    (12),
        .LEAD_ZEROS   (4),
        .QUIET_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    // ADC model: presents the next MSB-first bit on each falling edge while cs_n is low.
    logic [3:0][15:0] cur = '0;
    int unsigned      bit_i = 0;
    logic             in_frame = 1'b0;
    logic [3:0]       bidx;
    exp_t             e_new;

    always @(negedge clk) begin
        if (bus.cs_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                bit_i = 0;
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = '0;
                for (int k = 0; k < 4; k++) begin
                    e_new.s[k]  = cur[k][11:0];
                    e_new.le[k] = |cur[k][15:12];
                end
                exp_q.push_back(e_new);
            end
            if (bit_i < 16) begin
                bidx = 4'(15 - bit_i);
                bus.adc1 = cur[0][bidx];
                bus.adc2 = cur[1][bidx];
                bus.adc3 = cur[2][bidx];
                bus.adc4 = cur[3][bidx];
                bit_i++;
            end
        end else begin
            in_frame = 1'b0;
            bus.adc1 = 1'b0;
            bus.adc2 = 1'b0;
            bus.adc3 = 1'b0;
            bus.adc4 = 1'b0;
        end
    end

    int unsigned cyc = 0, low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    int unsigned fall_cyc = 0, dr_cyc = 0, dr_period = 0, fall_delay = 0, dr_count = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.cs_n === 1'b0) begin
            if (low_run == 0) begin
                fall_cyc = cyc;
                if (high_run != 0) last_high = high_run;
                high_run = 0;
            end
            low_run++;
        end else begin
            if (low_run != 0) begin
                last_low = low_run;
                low_run = 0;
            end
            high_run++;
        end
        if (bus.data_ready === 1'b1) begin
            dr_period  = cyc - dr_cyc;
            dr_cyc     = cyc;
            fall_delay = cyc - fall_cyc;
            dr_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] f1, input logic [15:0] f2,
                              input logic [15:0] f3, input logic [15:0] f4);
        logic [3:0][15:0] f;
        f[0] = f1; f[1] = f2; f[2] = f3; f[3] = f4;
        frame_q.push_back(f);
    endtask

    task automatic wait_cs_low(input string tag);
        int unsigned n = 0;
        logic found = 1'b0;
        while (!found && n < 64) begin
            tick();
            n++;
            if (bus.cs_n === 1'b0) found = 1'b1;
        end
        chk({tag, " cs fall"}, 32'(found), 1);
    endtask

    task automatic wait_ready(input string tag, input int unsigned limit,
                              output int unsigned waited);
        exp_t e;
        logic seen = 1'b0;
        waited = 0;
        while (!seen && waited < limit) begin
            tick();
            waited++;
            if (bus.data_ready === 1'b1) seen = 1'b1;
        end
        chk({tag, " ready seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, " sb depth"}, exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, " sample1"}, 32'(bus.sample1), 32'(e.s[0]));
                chk({tag, " sample2"}, 32'(bus.sample2), 32'(e.s[1]));
                chk({tag, " sample3"}, 32'(bus.sample3), 32'(e.s[2]));
                chk({tag, " sample4"}, 32'(bus.sample4), 32'(e.s[3]));
                chk({tag, " lead_err"}, 32'(bus.lead_err), 32'(e.le));
            end
            chk({tag, " low len"}, last_low, 16);
            chk({tag, " fall to ready"}, fall_delay, 16);
            tick();
            chk({tag, " strobe width"}, 32'(bus.data_ready), 0);
        end
    endtask

    initial begin
        int unsigned w;
        int unsigned cnt0;
        logic stayed;

        reset_b = 1'b1;
        bus.enable = 1'b0;
        bus.adc1 = 1'b0; bus.adc2 = 1'b0; bus.adc3 = 1'b0; bus.adc4 = 1'b0;
        #2 reset_b = 1'b0;
        repeat (3) tick();
        chk("rst cs_n", 32'(bus.cs_n), 1);
        chk("rst data_ready", 32'(bus.data_ready), 0);
        chk("rst sample1", 32'(bus.sample1), 0);
        chk("rst sample3", 32'(bus.sample3), 0);
        chk("rst lead_err", 32'(bus.lead_err), 0);

        push_frame(16'h0ABC, 16'h0000, 16'h0000, 16'h0000);
        push_frame(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        push_frame(16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF);
        push_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
        push_frame(16'h0555, 16'h0555, 16'h8123, 16'h0555);
        push_frame(16'h0321, 16'h0321, 16'h0321, 16'h0321);
        push_frame(16'h0456, 16'h0456, 16'h0456, 16'h0456);
        push_frame(16'h0789, 16'h0789, 16'h0789, 16'h0789);
        push_frame(16'h0AAA, 16'h0AAA, 16'h0AAA, 16'h0AAA);

        reset_b = 1'b1;
        bus.enable = 1'b1;

        // Single frame
        wait_ready("single", 64, w);
        chk("single s1 const", 32'(bus.sample1), 'hABC);
        chk("single lead const", 32'(bus.lead_err), 0);

        // Continuous stream
        wait_ready("stream 001", 40, w);
        chk("stream 001 period", dr_period, 19);
        chk("stream 001 cs high", last_high, 3);
        wait_ready("stream fff", 40, w);
        chk("stream fff period", dr_period, 19);
        chk("stream fff const", 32'(bus.sample4), 'hFFF);
        wait_ready("stream 800", 40, w);
        chk("stream 800 period", dr_period, 19);
        chk("stream 800 cs high", last_high, 3);

        // Lead error on lane 3, then a clean frame clears it
        wait_ready("lead", 40, w);
        chk("lead const", 32'(bus.lead_err), 'b0100);
        chk("lead sample3 const", 32'(bus.sample3), 'h123);
        wait_ready("clean", 40, w);
        chk("clean lead const", 32'(bus.lead_err), 0);

        // Enable drop after the 5th sampled bit
        wait_cs_low("drop");
        repeat (5) tick();
        bus.enable = 1'b0;
        wait_ready("drop", 40, w);
        cnt0 = dr_count;
        stayed = 1'b1;
        repeat (25) begin
            tick();
            if (bus.cs_n !== 1'b1) stayed = 1'b0;
        end
        chk("idle cs_n held", 32'(stayed), 1);
        chk("idle no strobe", dr_count - cnt0, 0);

        bus.enable = 1'b1;
        tick();
        tick();
        chk("reenable quiet", 32'(bus.cs_n), 1);
        tick();
        chk("reenable fall", 32'(bus.cs_n), 0);
        wait_ready("reenable", 40, w);

        // Reset at bit 8 of the next frame
        wait_cs_low("abort");
        repeat (7) tick();
        cnt0 = dr_count;
        reset_b = 1'b0;
        #1;
        chk("abort cs_n", 32'(bus.cs_n), 1);
        chk("abort sample1", 32'(bus.sample1), 0);
        chk("abort sample4", 32'(bus.sample4), 0);
        chk("abort lead_err", 32'(bus.lead_err), 0);
        chk("abort data_ready", 32'(bus.data_ready), 0);
        exp_q.delete();
        frame_q.delete();
        push_frame(16'h0BCD, 16'h0123, 16'h0F0F, 16'h0ACE);
        repeat (2) tick();
        reset_b = 1'b1;
        bus.enable = 1'b1;
        wait_ready("restart", 40, w);
        chk("restart latency", w, 19);
        chk("restart strobes", dr_count - cnt0, 1);
        chk("restart s1 const", 32'(bus.sample1), 'hBCD);

        bus.enable = 1'b0;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Upstream acquisition stage for the four hydrophone ADCs.
- Drives a shared active-low chip-select and shifts in one serial frame from each of the four ADC data lines in parallel.
- Strips the leading-zero field, checks it, and presents four parallel samples with a one-cycle data_ready strobe to the downstream processing/UART path.
- Clocked directly by the SPI clock, so the ADC serial clock pins and this block share one clock.

Parameters:
- FRAME_BITS, 16, SPI clocks per conversion frame (cs_n low duration).
- DATA_BITS, 12, sample width; the least-significant DATA_BITS of the frame.
- LEAD_ZEROS, 4, leading bits of each frame that must be zero; FRAME_BITS = LEAD_ZEROS + DATA_BITS is required (elaboration error otherwise).
- QUIET_CYCLES, 2, cs_n-high cycles between frames; minimum 1.

Ports:
- clk  input  1  SPI clock; all logic on its rising edge.
- reset_b  input  1  asynchronous active-low reset.
- enable  input  1  level; continuous conversion while high.
- adc1..adc4  input  1 each  serial data from the ADCs, MSB first.
- cs_n  output  1  shared chip-select, active low; top level fans it out to cs1..cs4.
- sample1..sample4  output  DATA_BITS each  latest captured samples, unsigned.
- lead_err  output  4  bit k-1 set if channel k's leading field was nonzero in the latest frame.
- data_ready  output  1  one-cycle strobe; samples and lead_err are valid on it.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; cs_n=1; sample1..4=0; lead_err=0; data_ready=0; counters=0.
  - A reset mid-frame raises cs_n without waiting for a clock edge.
- FSM (Moore, registered outputs):
  - IDLE: cs_n=1. enable=1 at an edge -> QUIET.
  - QUIET: cs_n=1; quiet_cnt counts 0..QUIET_CYCLES-1. At the edge where quiet_cnt=QUIET_CYCLES-1 -> SHIFT, bit_cnt=0.
  - SHIFT: cs_n=0. Each edge shifts adcN into shift register N (left shift, LSB in) and increments bit_cnt. At the edge sampling bit FRAME_BITS-1 -> DONE, and sampleN loads the low DATA_BITS of the completed frame (the shift value including that last bit).
  - At the same edge, lead_err[k] loads the OR of channel k's top LEAD_ZEROS bits.
  - DONE: cs_n=1; data_ready=1 for exactly this cycle. Next state is QUIET if enable=1, else IDLE.
- Timing:
  - data_ready is high from the edge after the 16th sampling edge, i.e. 16 clk after cs_n falls.
  - Frame period with continuous enable = FRAME_BITS + QUIET_CYCLES + 1 = 19 cycles at defaults.
- enable deassertion:
  - During SHIFT: the frame completes and data_ready still fires, then IDLE.
  - During QUIET: the block returns to IDLE at the next edge and cs_n never falls.
- sampleN and lead_err hold their values between data_ready strobes. A frame with lead_err set still updates its sample; no frame is dropped.
- bit_cnt width is clog2(FRAME_BITS+1). Counters never wrap within a frame.

Decomposition:
- Shared package acoustics_pkg holds:
  - FSM state enum: IDLE, QUIET, SHIFT, DONE.
  - Default ADC frame constants: FRAME_BITS, DATA_BITS, LEAD_ZEROS.
- Sub-module adc_shift_lane, instantiated 4x. Contents: FRAME_BITS shift register; output sample and lead_err registers loaded on the capture pulse from the parent FSM.

Test Plan:
- Single frame: reset released, enable=1, adc1 drives 0x0ABC MSB-first, adc2..4 drive 0x0000 while cs_n=0.
  - cs_n low for exactly 16 cycles.
  - data_ready pulses 1 cycle, 16 cycles after the cs_n fall.
  - sample1=0xABC, sample2..4=0x000, lead_err=0000.
- Continuous stream: enable held, frames 0x0001, 0x0FFF, 0x0800 on all lanes.
  - data_ready period exactly 19 cycles.
  - Samples follow 0x001, 0xFFF, 0x800.
  - cs_n high exactly 3 cycles between frames.
- Lead error: adc3 frame 0x8123.
  - sample3=0x123, lead_err=0100.
  - Next clean frame clears lead_err to 0000.
- Enable drop mid-SHIFT: enable=0 after the 5th bit.
  - Frame completes, data_ready fires once, then IDLE with cs_n=1 indefinitely.
  - Re-enable restarts with the QUIET phase.
- Reset mid-frame: reset_b=0 at bit 8.
  - cs_n=1 and all outputs 0 before the next clock edge; no data_ready.
  - After release with enable=1, the first data_ready arrives 19 cycles later with the correct sample.
